// File: rtl/cheri_pkg.sv
// ============================================================================
// Module      : cheri_pkg
// Description : Shared state and owner encodings for the TBRE/core LSU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cheri_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_TBRE = 2'd2
    } arb_owner_e;

    localparam logic [3:0] c_TBRE_BE = 4'hF;

endpackage

`default_nettype wire

// File: rtl/cheri_tbre_lsu_arb.sv
// ============================================================================
// Module      : cheri_tbre_lsu_arb
// Description : Arbitrates the core LSU and the TBRE onto one 33-bit memory
//               bus, splitting TBRE capability loads into two word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cheri_tbre_lsu_arb
    import cheri_pkg::*;
#(
    parameter int unsigned StarveLimit = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [32:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic        core_err_o,
    output logic [32:0] core_rdata_o,

    input  logic        tbre_lsu_req_i,
    input  logic        tbre_lsu_is_cap_i,
    input  logic        tbre_lsu_we_i,
    input  logic [31:0] tbre_lsu_addr_i,
    input  logic [32:0] tbre_lsu_wdata_i,
    output logic        lsu_tbre_req_done_o,
    output logic        lsu_tbre_addr_incr_o,
    output logic        lsu_tbre_resp_valid_o,
    output logic        lsu_tbre_resp_err_o,
    output logic        lsu_tbre_resp_is_wr_o,
    output logic [32:0] lsu_tbre_raw_lsw_o,

    output logic        snoop_lsu_req_done_o,
    output logic        snoop_lsu_we_o,
    output logic        snoop_lsu_is_cap_o,
    output logic [31:0] snoop_lsu_addr_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [32:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [32:0] data_rdata_i
);

    localparam int unsigned      c_CNT_W      = $clog2(StarveLimit + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(StarveLimit);

    arb_state_e          r_state, w_state_nxt;
    arb_owner_e          r_owner, w_owner_nxt;
    logic [c_CNT_W-1:0]  r_starve_cnt, w_starve_cnt_nxt;
    logic [32:0]         r_lsw;
    logic                r_err_q;
    logic                r_we_q;

    arb_owner_e          w_arb;
    arb_owner_e          w_iss_owner;
    arb_state_e          w_first_dst;
    logic                w_core_sel;
    logic                w_tbre_sel;
    logic                w_gnt;
    logic                w_tbre_gnt;
    logic                w_rvalid_final;

    assign w_rvalid_final = (r_state == ST_WAIT1) && data_rvalid_i;

    // Core has priority unless the TBRE has been starved StarveLimit times.
    always_comb begin
        w_arb = OWN_NONE;
        if (rst_ni) begin
            if (tbre_lsu_req_i && (!core_req_i || (r_starve_cnt == c_STARVE_MAX))) begin
                w_arb = OWN_TBRE;
            end else if (core_req_i) begin
                w_arb = OWN_CORE;
            end
        end
    end

    always_comb begin
        w_iss_owner = OWN_NONE;
        case (r_state)
            ST_IDLE: w_iss_owner = w_arb;
            ST_REQ0: begin
                if ((r_owner == OWN_CORE) && core_req_i) begin
                    w_iss_owner = OWN_CORE;
                end else if ((r_owner == OWN_TBRE) && tbre_lsu_req_i) begin
                    w_iss_owner = OWN_TBRE;
                end
            end
            ST_REQ1:  w_iss_owner = OWN_TBRE;
            ST_WAIT1: w_iss_owner = data_rvalid_i ? w_arb : OWN_NONE;
            default:  w_iss_owner = OWN_NONE;
        endcase
    end

    assign w_core_sel = (w_iss_owner == OWN_CORE);
    assign w_tbre_sel = (w_iss_owner == OWN_TBRE);

    always_comb begin
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_addr_o  = 32'h0;
        data_wdata_o = 33'h0;
        if (w_core_sel) begin
            data_req_o   = 1'b1;
            data_we_o    = core_we_i;
            data_be_o    = core_be_i;
            data_addr_o  = core_addr_i;
            data_wdata_o = core_wdata_i;
        end else if (w_tbre_sel) begin
            data_req_o   = 1'b1;
            data_we_o    = tbre_lsu_we_i;
            data_be_o    = c_TBRE_BE;
            data_addr_o  = tbre_lsu_addr_i;
            data_wdata_o = tbre_lsu_wdata_i;
        end
    end

    assign w_gnt      = data_req_o && data_gnt_i;
    assign w_tbre_gnt = w_gnt && w_tbre_sel;
    assign core_gnt_o = w_gnt && w_core_sel;

    // req_done only on the last word so the TBRE keeps req high across a cap load.
    assign lsu_tbre_req_done_o  = w_tbre_gnt && ((r_state == ST_REQ1) || !tbre_lsu_is_cap_i);
    assign lsu_tbre_addr_incr_o = (r_state == ST_REQ1);

    assign core_rvalid_o = w_rvalid_final && (r_owner == OWN_CORE);
    assign core_err_o    = core_rvalid_o && data_err_i;
    assign core_rdata_o  = core_rvalid_o ? data_rdata_i : 33'h0;

    assign lsu_tbre_resp_valid_o = w_rvalid_final && (r_owner == OWN_TBRE);
    assign lsu_tbre_resp_err_o   = lsu_tbre_resp_valid_o && (r_err_q || data_err_i);
    assign lsu_tbre_resp_is_wr_o = r_we_q;
    assign lsu_tbre_raw_lsw_o    = r_lsw;

    assign snoop_lsu_req_done_o = core_gnt_o;
    assign snoop_lsu_we_o       = core_gnt_o && core_we_i;
    assign snoop_lsu_is_cap_o   = 1'b0;
    assign snoop_lsu_addr_o     = core_gnt_o ? core_addr_i : 32'h0;

    assign w_first_dst = (w_tbre_sel && tbre_lsu_is_cap_i) ? ST_WAIT0 : ST_WAIT1;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE, ST_WAIT1: begin
                if ((r_state == ST_IDLE) || data_rvalid_i) begin
                    w_owner_nxt = w_iss_owner;
                    if (w_iss_owner == OWN_NONE) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_gnt) begin
                        w_state_nxt = w_first_dst;
                    end else begin
                        w_state_nxt = ST_REQ0;
                    end
                end
            end
            ST_REQ0: begin
                if (!data_req_o) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = OWN_NONE;
                end else if (w_gnt) begin
                    w_state_nxt = w_first_dst;
                end
            end
            ST_WAIT0: begin
                if (data_rvalid_i) begin
                    w_state_nxt = ST_REQ1;
                end
            end
            ST_REQ1: begin
                if (w_gnt) begin
                    w_state_nxt = ST_WAIT1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (!tbre_lsu_req_i || w_tbre_gnt) begin
            w_starve_cnt_nxt = '0;
        end else if (core_gnt_o && (r_starve_cnt != c_STARVE_MAX)) begin
            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
            r_lsw        <= 33'h0;
            r_err_q      <= 1'b0;
            r_we_q       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            if (w_tbre_gnt && (r_state != ST_REQ1)) begin
                r_we_q  <= tbre_lsu_we_i;
                r_err_q <= 1'b0;
            end
            // Word-0 error is remembered, not acted on: word 1 is still fetched.
            if ((r_state == ST_WAIT0) && data_rvalid_i) begin
                r_lsw   <= data_rdata_i;
                r_err_q <= r_err_q | data_err_i;
            end
        end
    end

`ifndef SYNTHESIS
    a_tbre_req_held_in_req1: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_REQ1) |-> tbre_lsu_req_i
    );

    a_rvalid_only_when_waiting: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        data_rvalid_i |-> ((r_state == ST_WAIT0) || (r_state == ST_WAIT1))
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_cheri_tbre_lsu_arb.sv
// ============================================================================
// Module      : tb_cheri_tbre_lsu_arb
// Description : Directed self-checking bench for cheri_tbre_lsu_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cheri_tbre_lsu_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i, core_we_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_addr_i;
    logic [32:0] core_wdata_i;
    logic        core_gnt_o, core_rvalid_o, core_err_o;
    logic [32:0] core_rdata_o;
    logic        tbre_lsu_req_i, tbre_lsu_is_cap_i, tbre_lsu_we_i;
    logic [31:0] tbre_lsu_addr_i, tbre_base;
    logic [32:0] tbre_lsu_wdata_i;
    logic        lsu_tbre_req_done_o, lsu_tbre_addr_incr_o, lsu_tbre_resp_valid_o;
    logic        lsu_tbre_resp_err_o, lsu_tbre_resp_is_wr_o;
    logic [32:0] lsu_tbre_raw_lsw_o;
    logic        snoop_lsu_req_done_o, snoop_lsu_we_o, snoop_lsu_is_cap_o;
    logic [31:0] snoop_lsu_addr_o;
    logic        data_req_o, data_gnt_i, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [32:0] data_wdata_o;
    logic        data_rvalid_i, data_err_i;
    logic [32:0] data_rdata_i;

    logic        gnt_en;
    logic [31:0] err_addr;
    logic        mem_rv;
    logic [31:0] mem_addr;

    int checks = 0;
    int errors = 0;

    cheri_tbre_lsu_arb #(.StarveLimit(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_err_o(core_err_o), .core_rdata_o(core_rdata_o),
        .tbre_lsu_req_i(tbre_lsu_req_i), .tbre_lsu_is_cap_i(tbre_lsu_is_cap_i),
        .tbre_lsu_we_i(tbre_lsu_we_i), .tbre_lsu_addr_i(tbre_lsu_addr_i),
        .tbre_lsu_wdata_i(tbre_lsu_wdata_i),
        .lsu_tbre_req_done_o(lsu_tbre_req_done_o),
        .lsu_tbre_addr_incr_o(lsu_tbre_addr_incr_o),
        .lsu_tbre_resp_valid_o(lsu_tbre_resp_valid_o),
        .lsu_tbre_resp_err_o(lsu_tbre_resp_err_o),
        .lsu_tbre_resp_is_wr_o(lsu_tbre_resp_is_wr_o),
        .lsu_tbre_raw_lsw_o(lsu_tbre_raw_lsw_o),
        .snoop_lsu_req_done_o(snoop_lsu_req_done_o), .snoop_lsu_we_o(snoop_lsu_we_o),
        .snoop_lsu_is_cap_o(snoop_lsu_is_cap_o), .snoop_lsu_addr_o(snoop_lsu_addr_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [32:0] mem_data(input logic [31:0] a);
        if (a == 32'h1000) return 33'h1_AAAA_0000;
        if (a == 32'h1004) return 33'h0_BBBB_0000;
        return {1'b0, a ^ 32'h5A5A_0000};
    endfunction

    // TBRE presents addr+4 itself while addr_incr is high.
    assign tbre_lsu_addr_i = tbre_base + (lsu_tbre_addr_incr_o ? 32'd4 : 32'd0);
    assign data_gnt_i      = data_req_o && gnt_en;
    assign data_rvalid_i   = mem_rv;
    assign data_rdata_i    = mem_rv ? mem_data(mem_addr) : 33'h0;
    assign data_err_i      = mem_rv && (mem_addr == err_addr);

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_rv   <= 1'b0;
            mem_addr <= 32'h0;
        end else begin
            mem_rv   <= data_req_o && data_gnt_i;
            mem_addr <= data_addr_o;
        end
    end

    // Event log sampled mid-cycle.
    logic [7:0]  g_who   [256];
    logic [31:0] g_addr  [256];
    logic        g_we    [256];
    logic [3:0]  g_be    [256];
    logic [32:0] g_wdata [256];
    int n_gnt = 0, n_done = 0, n_incr = 0, n_resp = 0, n_core_rv = 0, n_snoop = 0;
    logic [31:0] done_addr, incr_addr, snoop_addr;
    logic        resp_err, resp_is_wr, snoop_we, snoop_cap;
    logic [32:0] resp_lsw, core_rdata;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (data_req_o && data_gnt_i && n_gnt < 256) begin
                g_who[n_gnt]   <= core_gnt_o ? 8'h43 : 8'h54;
                g_addr[n_gnt]  <= data_addr_o;
                g_we[n_gnt]    <= data_we_o;
                g_be[n_gnt]    <= data_be_o;
                g_wdata[n_gnt] <= data_wdata_o;
                n_gnt          <= n_gnt + 1;
            end
            if (lsu_tbre_req_done_o) begin
                n_done <= n_done + 1;  done_addr <= data_addr_o;
            end
            if (lsu_tbre_addr_incr_o) begin
                n_incr <= n_incr + 1;  incr_addr <= data_addr_o;
            end
            if (lsu_tbre_resp_valid_o) begin
                n_resp     <= n_resp + 1;
                resp_err   <= lsu_tbre_resp_err_o;
                resp_is_wr <= lsu_tbre_resp_is_wr_o;
                resp_lsw   <= lsu_tbre_raw_lsw_o;
            end
            if (core_rvalid_o) begin
                n_core_rv <= n_core_rv + 1;  core_rdata <= core_rdata_o;
            end
            if (snoop_lsu_req_done_o) begin
                n_snoop    <= n_snoop + 1;
                snoop_addr <= snoop_lsu_addr_o;
                snoop_we   <= snoop_lsu_we_o;
                snoop_cap  <= snoop_lsu_is_cap_o;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_done_and_drop();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (lsu_tbre_req_done_o) break;
        end
        tick();
        tbre_lsu_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        core_req_i = 1'b1;  tbre_lsu_req_i = 1'b1;
        core_addr_i = 32'hDEAD_0000;  tbre_base = 32'h0000_1000;
        @(negedge clk_i);
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL reset_data_req: got %b expected 0", data_req_o); end
        checks++; if (core_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_core_gnt: got %b expected 0", core_gnt_o); end
        checks++; if (lsu_tbre_addr_incr_o !== 1'b0) begin errors++; $display("FAIL reset_addr_incr: got %b expected 0", lsu_tbre_addr_incr_o); end
        checks++; if (lsu_tbre_raw_lsw_o !== 33'h0) begin errors++; $display("FAIL reset_raw_lsw: got %h expected 0", lsu_tbre_raw_lsw_o); end
        checks++; if (data_addr_o !== 32'h0 || snoop_lsu_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h/%h expected 0/0", data_addr_o, snoop_lsu_addr_o); end
        tick();
        core_req_i = 1'b0;  tbre_lsu_req_i = 1'b0;
        rst_ni = 1'b1;
        tick(2);
    endtask

    task automatic test_cap_load();
        int bg = n_gnt, bd = n_done, bi = n_incr, br = n_resp;
        tbre_base = 32'h1000;  tbre_lsu_is_cap_i = 1'b1;  tbre_lsu_we_i = 1'b0;
        tbre_lsu_req_i = 1'b1;
        wait_done_and_drop();
        tick(4);
        checks++; if (n_gnt - bg !== 2) begin errors++; $display("FAIL cap_gnt_count: got %0d expected 2", n_gnt - bg); end
        checks++; if (g_addr[bg] !== 32'h1000 || g_addr[bg+1] !== 32'h1004) begin errors++; $display("FAIL cap_addrs: got %h,%h expected 1000,1004", g_addr[bg], g_addr[bg+1]); end
        checks++; if (g_be[bg] !== 4'hF) begin errors++; $display("FAIL cap_be: got %h expected f", g_be[bg]); end
        checks++; if (n_incr - bi !== 1 || incr_addr !== 32'h1004) begin errors++; $display("FAIL cap_addr_incr: got %0d cycles addr %h expected 1 cycle addr 1004", n_incr - bi, incr_addr); end
        checks++; if (n_done - bd !== 1 || done_addr !== 32'h1004) begin errors++; $display("FAIL cap_req_done: got %0d pulses at %h expected 1 at 1004", n_done - bd, done_addr); end
        checks++; if (n_resp - br !== 1) begin errors++; $display("FAIL cap_resp_count: got %0d expected 1", n_resp - br); end
        checks++; if (resp_lsw !== 33'h1_AAAA_0000) begin errors++; $display("FAIL cap_raw_lsw: got %h expected 1aaaa0000", resp_lsw); end
        checks++; if (resp_err !== 1'b0 || resp_is_wr !== 1'b0) begin errors++; $display("FAIL cap_err_wr: got %b%b expected 00", resp_err, resp_is_wr); end
    endtask

    task automatic test_cap_err();
        int bg = n_gnt, br = n_resp;
        err_addr = 32'h2000;
        tbre_base = 32'h2000;  tbre_lsu_is_cap_i = 1'b1;  tbre_lsu_we_i = 1'b0;
        tbre_lsu_req_i = 1'b1;
        wait_done_and_drop();
        tick(4);
        err_addr = 32'hFFFF_FFFF;
        checks++; if (n_gnt - bg !== 2 || g_addr[bg+1] !== 32'h2004) begin errors++; $display("FAIL err_second_word: got %0d grants last %h expected 2 last 2004", n_gnt - bg, g_addr[bg+1]); end
        checks++; if (n_resp - br !== 1 || resp_err !== 1'b1) begin errors++; $display("FAIL err_resp: got %0d resp err %b expected 1 resp err 1", n_resp - br, resp_err); end
        checks++; if (resp_lsw !== 33'h0_5A5A_2000) begin errors++; $display("FAIL err_raw_lsw: got %h expected 05a5a2000", resp_lsw); end
    endtask

    task automatic test_starvation();
        int bg = n_gnt, bd = n_done, bc = n_core_rv;
        logic [7:0] exp_who [6];
        exp_who = '{8'h43, 8'h43, 8'h54, 8'h43, 8'h43, 8'h54};
        core_addr_i = 32'h3000;  core_we_i = 1'b0;  core_be_i = 4'hF;
        tbre_base = 32'h4000;  tbre_lsu_is_cap_i = 1'b0;  tbre_lsu_we_i = 1'b0;
        core_req_i = 1'b1;  tbre_lsu_req_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            #1;
            if (n_gnt - bg >= 6) break;
        end
        tick();
        core_req_i = 1'b0;  tbre_lsu_req_i = 1'b0;
        tick(4);
        checks++; if (n_gnt - bg < 6) begin errors++; $display("FAIL starve_grants: got %0d expected at least 6", n_gnt - bg); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (g_who[bg+i] !== exp_who[i]) begin errors++; $display("FAIL starve_order[%0d]: got %c expected %c", i, g_who[bg+i], exp_who[i]); end
        end
        checks++; if (n_done - bd !== 2 || n_core_rv - bc !== 4) begin errors++; $display("FAIL starve_resp: got %0d done %0d core rvalid expected 2/4", n_done - bd, n_core_rv - bc); end
        checks++; if (core_rdata !== 33'h0_5A5A_3000) begin errors++; $display("FAIL starve_core_rdata: got %h expected 05a5a3000", core_rdata); end
    endtask

    task automatic test_snoop();
        int bg = n_gnt, bs = n_snoop, bc = n_core_rv, bd, br;
        core_addr_i = 32'h1008;  core_we_i = 1'b1;  core_be_i = 4'h3;
        core_wdata_i = 33'h1_1234_5678;  core_req_i = 1'b1;
        tick();
        core_req_i = 1'b0;
        tick(3);
        checks++; if (n_snoop - bs !== 1 || snoop_addr !== 32'h1008) begin errors++; $display("FAIL snoop_core: got %0d snoops addr %h expected 1 addr 1008", n_snoop - bs, snoop_addr); end
        checks++; if (snoop_we !== 1'b1 || snoop_cap !== 1'b0) begin errors++; $display("FAIL snoop_flags: got we %b cap %b expected we 1 cap 0", snoop_we, snoop_cap); end
        checks++; if (g_be[bg] !== 4'h3 || g_wdata[bg] !== 33'h1_1234_5678) begin errors++; $display("FAIL core_write_mux: got be %h wdata %h expected 3 112345678", g_be[bg], g_wdata[bg]); end
        checks++; if (n_core_rv - bc !== 1) begin errors++; $display("FAIL core_write_resp: got %0d expected 1", n_core_rv - bc); end
        bg = n_gnt;  bs = n_snoop;  bd = n_done;  br = n_resp;
        tbre_base = 32'h5000;  tbre_lsu_is_cap_i = 1'b0;  tbre_lsu_we_i = 1'b1;
        tbre_lsu_wdata_i = 33'h0_CAFE_F00D;  tbre_lsu_req_i = 1'b1;
        wait_done_and_drop();
        tick(3);
        checks++; if (n_snoop - bs !== 0) begin errors++; $display("FAIL tbre_no_snoop: got %0d snoops expected 0", n_snoop - bs); end
        checks++; if (g_we[bg] !== 1'b1 || g_be[bg] !== 4'hF || g_wdata[bg] !== 33'h0_CAFE_F00D) begin errors++; $display("FAIL tbre_write_mux: got we %b be %h wdata %h expected 1 f 0cafef00d", g_we[bg], g_be[bg], g_wdata[bg]); end
        checks++; if (n_done - bd !== 1 || n_resp - br !== 1 || resp_is_wr !== 1'b1) begin errors++; $display("FAIL tbre_write_resp: got done %0d resp %0d is_wr %b expected 1 1 1", n_done - bd, n_resp - br, resp_is_wr); end
    endtask

    task automatic test_drop();
        int br = n_resp, bc = n_core_rv;
        gnt_en = 1'b0;
        tbre_base = 32'h6000;  tbre_lsu_is_cap_i = 1'b0;  tbre_lsu_we_i = 1'b1;
        tbre_lsu_req_i = 1'b1;
        core_addr_i = 32'h6100;  core_we_i = 1'b0;  core_be_i = 4'hF;
        @(negedge clk_i);
        checks++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h6000) begin errors++; $display("FAIL drop_pending: got req %b addr %h expected 1 6000", data_req_o, data_addr_o); end
        tick();
        tbre_lsu_req_i = 1'b0;  core_req_i = 1'b1;  gnt_en = 1'b1;
        @(negedge clk_i);
        checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL drop_release: got req %b expected 0", data_req_o); end
        tick();
        @(negedge clk_i);
        checks++; if (core_gnt_o !== 1'b1 || data_addr_o !== 32'h6100) begin errors++; $display("FAIL drop_core_next: got gnt %b addr %h expected 1 6100", core_gnt_o, data_addr_o); end
        tick();
        core_req_i = 1'b0;
        tick(3);
        checks++; if (n_resp - br !== 0 || n_core_rv - bc !== 1) begin errors++; $display("FAIL drop_resp: got tbre %0d core %0d expected 0 1", n_resp - br, n_core_rv - bc); end
    endtask

    task automatic test_back_to_back();
        int br;
        logic seen = 1'b0;
        tbre_base = 32'h7000;  tbre_lsu_is_cap_i = 1'b1;  tbre_lsu_we_i = 1'b0;
        tbre_lsu_req_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (lsu_tbre_resp_valid_o) begin
                seen = 1'b1;
                checks++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h7000) begin errors++; $display("FAIL b2b_reissue: got req %b addr %h expected 1 7000", data_req_o, data_addr_o); end
                checks++; if (lsu_tbre_raw_lsw_o !== 33'h0_5A5A_7000) begin errors++; $display("FAIL b2b_raw_lsw: got %h expected 05a5a7000", lsu_tbre_raw_lsw_o); end
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_timeout: got no resp_valid expected one"); end
        tick();
        rst_ni = 1'b0;
        #1;
        br = n_resp;
        @(negedge clk_i);
        checks++; if (data_req_o !== 1'b0 || lsu_tbre_resp_valid_o !== 1'b0 || lsu_tbre_addr_incr_o !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got req %b resp %b incr %b expected 000", data_req_o, lsu_tbre_resp_valid_o, lsu_tbre_addr_incr_o); end
        checks++; if (lsu_tbre_raw_lsw_o !== 33'h0 || lsu_tbre_req_done_o !== 1'b0) begin errors++; $display("FAIL rst_mid_regs: got lsw %h done %b expected 0 0", lsu_tbre_raw_lsw_o, lsu_tbre_req_done_o); end
        tick();
        tbre_lsu_req_i = 1'b0;
        rst_ni = 1'b1;
        tick(5);
        checks++; if (n_resp !== br || data_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp: got %0d responses req %b expected 0 0", n_resp - br, data_req_o); end
    endtask

    initial begin
        rst_ni = 1'b0;
        core_req_i = 1'b0;  core_we_i = 1'b0;  core_be_i = 4'h0;
        core_addr_i = 32'h0;  core_wdata_i = 33'h0;
        tbre_lsu_req_i = 1'b0;  tbre_lsu_is_cap_i = 1'b0;  tbre_lsu_we_i = 1'b0;
        tbre_base = 32'h0;  tbre_lsu_wdata_i = 33'h0;
        gnt_en = 1'b1;  err_addr = 32'hFFFF_FFFF;
        tick(2);
        test_reset();
        test_cap_load();
        test_cap_err();
        test_starvation();
        test_snoop();
        test_drop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cheri_tbre_lsu_arb.md
Name: cheri_tbre_lsu_arb

Overview:
- Responder/arbiter that sits between the core LSU data port, the background revocation engine (TBRE) LSU request port, and the single 33-bit (32 data + tag) data-memory bus.
- Grants one requester at a time and splits TBRE capability loads into two word accesses (addr, addr+4), sequencing them with the addr_incr handshake.
- Returns responses to the owner and broadcasts core write snoops back to the TBRE.
- Memory model is non-buffered: at most one outstanding memory request.

Parameters:
- StarveLimit, 8: consecutive core grants while a TBRE request is pending before one TBRE grant is forced; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- core_req_i  in  1  core word request
- core_we_i  in  1  core write
- core_be_i  in  4  core byte enables
- core_addr_i  in  32  core word address
- core_wdata_i  in  33  core write data incl. tag [32]
- core_gnt_o  out  1  core request accepted by memory
- core_rvalid_o  out  1  core response valid
- core_err_o  out  1  core response error
- core_rdata_o  out  33  core read data
- tbre_lsu_req_i  in  1  TBRE request (may drop before first-word grant)
- tbre_lsu_is_cap_i  in  1  TBRE cap (2-word) load
- tbre_lsu_we_i  in  1  TBRE word write
- tbre_lsu_addr_i  in  32  TBRE address (already includes +4 when addr_incr_o=1)
- tbre_lsu_wdata_i  in  33  TBRE write data
- lsu_tbre_req_done_o  out  1  TBRE transaction fully granted
- lsu_tbre_addr_incr_o  out  1  second word of TBRE cap access in progress
- lsu_tbre_resp_valid_o  out  1  TBRE transaction response
- lsu_tbre_resp_err_o  out  1  TBRE response error
- lsu_tbre_resp_is_wr_o  out  1  response belongs to a write
- lsu_tbre_raw_lsw_o  out  33  least-significant word (with tag) of the loaded cap
- snoop_lsu_req_done_o  out  1  core request granted (snoop)
- snoop_lsu_we_o  out  1  snooped request is a write
- snoop_lsu_is_cap_o  out  1  always 0 (core port is word-only)
- snoop_lsu_addr_o  out  32  snooped address
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_we_o  out  1  memory write
- data_be_o  out  4  memory byte enables
- data_addr_o  out  32  memory address
- data_wdata_o  out  33  memory write data
- data_rvalid_i  in  1  memory response
- data_err_i  in  1  memory error
- data_rdata_i  in  33  memory read data

Behaviour:
- Reset values: all outputs 0. FSM = IDLE, owner = NONE, starve counter = 0.
- FSM states:
  - IDLE: no transaction.
  - REQ0: first word requested, awaiting gnt.
  - WAIT0: awaiting rvalid of word 0 (TBRE cap only).
  - REQ1: second word requested.
  - WAIT1: awaiting final rvalid.
- Arbitration: evaluated combinationally in IDLE, and in WAIT1 in the cycle data_rvalid_i arrives (back-to-back issue allowed).
  - Core wins unless tbre_lsu_req_i=1 and starve counter == StarveLimit.
  - Starve counter increments on each core grant while tbre_lsu_req_i=1; clears on any TBRE grant or when tbre_lsu_req_i=0.
- Datapath mux: data_req_o/we/be/addr/wdata are selected from the owner. The TBRE always drives be=4'hF.
- Ownership lock: ownership is locked from the first-word grant until the final rvalid.
  - Before the first-word grant, a requester that drops its req releases ownership that cycle: data_req_o falls and the FSM returns to IDLE.
- Core transaction:
  - REQ0 → (gnt) WAIT1 → (rvalid) IDLE or new grant.
  - core_gnt_o = data_gnt_i & owner==CORE.
  - core_rvalid_o/err/rdata pass through combinationally in WAIT1.
- TBRE word write or non-cap read: same path as a core transaction.
  - lsu_tbre_req_done_o = gnt.
  - resp_valid on rvalid, with is_wr = latched we.
- TBRE cap load:
  - REQ0 (gnt) → WAIT0 (rvalid: latch rdata into lsw register and OR err into err_q) → REQ1.
  - REQ1 drives lsu_tbre_addr_incr_o=1; the TBRE presents addr+4 and the block forwards it unchanged.
  - REQ1 (gnt: lsu_tbre_req_done_o=1) → WAIT1 (rvalid: resp_valid=1, err = err_q | data_err_i, raw_lsw = lsw register).
  - An error on word 0 does not abort: the block still issues word 1.
- req_done: a single-cycle pulse per transaction, only on the final-word grant, so the TBRE holds req across both words.
- TBRE req in REQ1: must stay high; a drop there is a protocol violation (assert).
- lsu_tbre_addr_incr_o is held through REQ1 only.
- lsu_tbre_raw_lsw_o and resp_is_wr_o are valid only with resp_valid. They are driven from registers (lsw, we_q), so no data_rdata_i→TBRE combinational path exists except resp_valid.
- Snoop: snoop_lsu_req_done_o = core grant (data_gnt_i & owner==CORE), with addr/we = core request fields in the same cycle. TBRE grants are never snooped.
- Memory-side faults: rvalid outside WAIT0/WAIT1 is ignored (assert). gnt while data_req_o=0 is ignored.
- Reset mid-transaction: asynchronous return to IDLE. No response is delivered.

Decomposition:
- cheri_pkg: state enum (IDLE, REQ0, WAIT0, REQ1, WAIT1) and owner enum (NONE, CORE, TBRE).
- No sub-module: FSM, starve counter and output mux form a single module of roughly 200 lines.

Test Plan:
- TBRE cap load addr 0x1000, memory returns 0x1_AAAA0000 then 0x0_BBBB0000 → data_addr 0x1000 then 0x1004; addr_incr=1 only in REQ1; req_done one pulse at 2nd gnt; resp_valid with raw_lsw=0x1_AAAA0000, err=0.
- Word 0 returns err=1 and word 1 returns err=0 → second access still issued; resp_err=1.
- Core and TBRE both request continuously, StarveLimit=2 → grant order core, core, TBRE, core, core, TBRE.
- Core write to 0x1008 → snoop_lsu_req_done=1, we=1, addr=0x1008, is_cap=0 in the gnt cycle; TBRE write gets no snoop.
- TBRE store drops req before gnt → data_req_o falls the same cycle; core request granted next cycle; no resp_valid.
- Back-to-back: final rvalid of a TBRE load with tbre req high → data_req_o=1 the same cycle; reset asserted in WAIT0 → all outputs 0 and no response afterwards.
